// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline hazard signal bundle between the CPU pipeline
//               (master) and the hazard sequencing controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
);
  // Hazard sources from the pipeline
  logic [REG_ADDR_W-1:0] id_reg1_addr;
  logic                  id_reg1_re;
  logic [REG_ADDR_W-1:0] id_reg2_addr;
  logic                  id_reg2_re;
  logic [REG_ADDR_W-1:0] ex_wb_addr;
  logic                  ex_reg_we;
  logic                  ex_is_load;
  logic                  id_branch_taken;
  logic                  mem_ram_req;
  logic                  perf_clr;

  // Pipeline register controls
  logic                  pc_hold;
  logic                  if_id_hold;
  logic                  if_id_flush;
  logic                  id_ex_hold;
  logic                  id_ex_bubble;
  logic                  ex_mem_hold;
  logic                  mem_wb_bubble;

  // Debug statistics
  logic [CNT_W-1:0]      stat_load_stall;
  logic [CNT_W-1:0]      stat_mem_stall;
  logic [CNT_W-1:0]      stat_flush;

  modport master (
    output id_reg1_addr, id_reg1_re, id_reg2_addr, id_reg2_re,
           ex_wb_addr, ex_reg_we, ex_is_load, id_branch_taken,
           mem_ram_req, perf_clr,
    input  pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_mem_hold, mem_wb_bubble,
           stat_load_stall, stat_mem_stall, stat_flush
  );

  modport slave (
    input  id_reg1_addr, id_reg1_re, id_reg2_addr, id_reg2_re,
           ex_wb_addr, ex_reg_we, ex_is_load, id_branch_taken,
           mem_ram_req, perf_clr,
    output pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble,
           ex_mem_hold, mem_wb_bubble,
           stat_load_stall, stat_mem_stall, stat_flush
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Five-stage pipeline sequencing controller. Resolves load-use,
//               shared instruction/data RAM wait and taken-branch hazards and
//               keeps saturating stall/flush statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int RAM_WAIT   = 2,   // legal range 1..15
  parameter int CNT_W      = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,      // asynchronous, active low
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  // Index of the final cycle of a shared-RAM access
  localparam logic [3:0] c_last_wait = 4'(RAM_WAIT - 1);

  state_t                r_state;
  logic [3:0]            r_wait_cnt;
  logic [CNT_W-1:0]      r_stat_load_stall;
  logic [CNT_W-1:0]      r_stat_mem_stall;
  logic [CNT_W-1:0]      r_stat_flush;

  logic [REG_ADDR_W-1:0] w_ex_dst;
  logic [3:0]            w_wait_cnt;
  logic                  w_load_use;
  logic                  w_freeze;
  logic                  w_release;

  // Hazard detection: the count only means something while a wait is running
  assign w_ex_dst   = bus.ex_wb_addr;
  assign w_wait_cnt = (r_state == ST_MEM_WAIT) ? r_wait_cnt : 4'd0;
  assign w_load_use = bus.ex_is_load & bus.ex_reg_we &
                      ((bus.id_reg1_re & (bus.id_reg1_addr == w_ex_dst)) |
                       (bus.id_reg2_re & (bus.id_reg2_addr == w_ex_dst)));
  assign w_freeze   = bus.mem_ram_req & (w_wait_cnt != c_last_wait);
  assign w_release  = bus.mem_ram_req & (w_wait_cnt == c_last_wait);

  // Priority-ordered pipeline register controls, forced idle while in reset
  always_comb begin
    bus.pc_hold       = 1'b0;
    bus.if_id_hold    = 1'b0;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_hold    = 1'b0;
    bus.id_ex_bubble  = 1'b0;
    bus.ex_mem_hold   = 1'b0;
    bus.mem_wb_bubble = 1'b0;
    if (rst) begin
      if (w_freeze) begin
        // RAM busy with a data access: freeze everything upstream of MEM
        bus.pc_hold       = 1'b1;
        bus.if_id_hold    = 1'b1;
        bus.id_ex_hold    = 1'b1;
        bus.ex_mem_hold   = 1'b1;
        bus.mem_wb_bubble = 1'b1;
      end else if (w_load_use) begin
        // Stall decode one cycle; a pending branch is re-evaluated next cycle
        bus.pc_hold      = 1'b1;
        bus.if_id_hold   = 1'b1;
        bus.id_ex_bubble = 1'b1;
      end else if (w_release) begin
        // No fetch happened this access: IF/ID gets a NOP; PC only moves
        // if a branch target must be loaded
        bus.if_id_flush = 1'b1;
        bus.pc_hold     = ~bus.id_branch_taken;
      end else if (bus.id_branch_taken) begin
        bus.if_id_flush = 1'b1;
      end
    end
  end

  // Wait sequencer: count freeze cycles, return to RUN on release or drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 4'd0;
    end else if (w_freeze) begin
      r_state    <= ST_MEM_WAIT;
      r_wait_cnt <= w_wait_cnt + 4'd1;
    end else begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 4'd0;
    end
  end

  // Saturating statistics counters with synchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_load_stall <= '0;
      r_stat_mem_stall  <= '0;
      r_stat_flush      <= '0;
    end else if (bus.perf_clr) begin
      r_stat_load_stall <= '0;
      r_stat_mem_stall  <= '0;
      r_stat_flush      <= '0;
    end else begin
      if (!w_freeze && w_load_use && (r_stat_load_stall != '1))
        r_stat_load_stall <= r_stat_load_stall + 1'b1;
      if ((w_freeze || w_release) && (r_stat_mem_stall != '1))
        r_stat_mem_stall <= r_stat_mem_stall + 1'b1;
      if (bus.if_id_flush && bus.id_branch_taken && (r_stat_flush != '1))
        r_stat_flush <= r_stat_flush + 1'b1;
    end
  end

  assign bus.stat_load_stall = r_stat_load_stall;
  assign bus.stat_mem_stall  = r_stat_mem_stall;
  assign bus.stat_flush      = r_stat_flush;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl. Instance A uses
//               RAM_WAIT=3 / CNT_W=4, instance B uses RAM_WAIT=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(4))  bus_a ();
  hazard_ctrl_if #(.REG_ADDR_W(4), .CNT_W(16)) bus_b ();

  hazard_ctrl #(.REG_ADDR_W(4), .RAM_WAIT(3), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  hazard_ctrl #(.REG_ADDR_W(4), .RAM_WAIT(1), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Control vector: {pc_hold, if_id_hold, if_id_flush, id_ex_hold,
  //                  id_ex_bubble, ex_mem_hold, mem_wb_bubble}
  localparam logic [6:0] c_idle    = 7'b0000000;
  localparam logic [6:0] c_freeze  = 7'b1101011;
  localparam logic [6:0] c_ld_use  = 7'b1100100;
  localparam logic [6:0] c_rel     = 7'b1010000;
  localparam logic [6:0] c_rel_br  = 7'b0010000;
  localparam logic [6:0] c_branch  = 7'b0010000;

  function automatic logic [6:0] ctl_a();
    return {bus_a.pc_hold, bus_a.if_id_hold, bus_a.if_id_flush,
            bus_a.id_ex_hold, bus_a.id_ex_bubble, bus_a.ex_mem_hold,
            bus_a.mem_wb_bubble};
  endfunction

  function automatic logic [6:0] ctl_b();
    return {bus_b.pc_hold, bus_b.if_id_hold, bus_b.if_id_flush,
            bus_b.id_ex_hold, bus_b.id_ex_bubble, bus_b.ex_mem_hold,
            bus_b.mem_wb_bubble};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    bus_a.id_reg1_addr    = 4'd0;
    bus_a.id_reg1_re      = 1'b0;
    bus_a.id_reg2_addr    = 4'd0;
    bus_a.id_reg2_re      = 1'b0;
    bus_a.ex_wb_addr      = 4'd0;
    bus_a.ex_reg_we       = 1'b0;
    bus_a.ex_is_load      = 1'b0;
    bus_a.id_branch_taken = 1'b0;
    bus_a.mem_ram_req     = 1'b0;
    bus_a.perf_clr        = 1'b0;
  endtask

  task automatic set_load_use_a();
    bus_a.ex_is_load   = 1'b1;
    bus_a.ex_reg_we    = 1'b1;
    bus_a.ex_wb_addr   = 4'd3;
    bus_a.id_reg2_addr = 4'd3;
    bus_a.id_reg2_re   = 1'b1;
  endtask

  initial begin
    clear_a();
    bus_b.id_reg1_addr    = 4'd0;
    bus_b.id_reg1_re      = 1'b0;
    bus_b.id_reg2_addr    = 4'd0;
    bus_b.id_reg2_re      = 1'b0;
    bus_b.ex_wb_addr      = 4'd0;
    bus_b.ex_reg_we       = 1'b0;
    bus_b.ex_is_load      = 1'b0;
    bus_b.id_branch_taken = 1'b0;
    bus_b.mem_ram_req     = 1'b0;
    bus_b.perf_clr        = 1'b0;

    // Reset state
    #2;
    chk("reset_ctl", 32'(ctl_a()), 32'(c_idle));
    chk("reset_stats", 32'({bus_a.stat_load_stall, bus_a.stat_mem_stall,
                            bus_a.stat_flush}), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Load-use on source 2
    set_load_use_a();
    #1;
    chk("load_use_ctl", 32'(ctl_a()), 32'(c_ld_use));
    step();
    clear_a();
    #1;
    chk("load_use_after_ctl", 32'(ctl_a()), 32'(c_idle));
    chk("load_use_stat", 32'(bus_a.stat_load_stall), 32'd1);

    // Same addresses but source 2 not read: no stall
    set_load_use_a();
    bus_a.id_reg2_re = 1'b0;
    #1;
    chk("no_read_ctl", 32'(ctl_a()), 32'(c_idle));
    step();
    clear_a();
    chk("no_read_stat", 32'(bus_a.stat_load_stall), 32'd1);

    // Branch taken alone
    bus_a.id_branch_taken = 1'b1;
    #1;
    chk("branch_ctl", 32'(ctl_a()), 32'(c_branch));
    step();
    chk("branch_stat", 32'(bus_a.stat_flush), 32'd1);

    // Branch with load-use: stall, no flush
    set_load_use_a();
    #1;
    chk("branch_lu_ctl", 32'(ctl_a()), 32'(c_ld_use));
    step();
    clear_a();
    chk("branch_lu_flush_stat", 32'(bus_a.stat_flush), 32'd1);
    chk("branch_lu_load_stat", 32'(bus_a.stat_load_stall), 32'd2);

    // Shared RAM wait, RAM_WAIT=3: two freezes then a release
    bus_a.mem_ram_req = 1'b1;
    #1;
    chk("ram_freeze0", 32'(ctl_a()), 32'(c_freeze));
    step();
    chk("ram_freeze1", 32'(ctl_a()), 32'(c_freeze));
    step();
    chk("ram_release", 32'(ctl_a()), 32'(c_rel));
    step();
    bus_a.mem_ram_req = 1'b0;
    #1;
    chk("ram_mem_stat", 32'(bus_a.stat_mem_stall), 32'd3);
    chk("ram_after_ctl", 32'(ctl_a()), 32'(c_idle));

    // Branch resolved on the release cycle
    bus_a.mem_ram_req = 1'b1;
    step();
    step();
    bus_a.id_branch_taken = 1'b1;
    #1;
    chk("rel_branch_ctl", 32'(ctl_a()), 32'(c_rel_br));
    step();
    clear_a();
    chk("rel_branch_flush_stat", 32'(bus_a.stat_flush), 32'd2);
    chk("rel_branch_mem_stat", 32'(bus_a.stat_mem_stall), 32'd6);

    // Load-use during freeze is ignored; on release it stalls without flush
    bus_a.mem_ram_req = 1'b1;
    set_load_use_a();
    #1;
    chk("freeze_lu_ctl", 32'(ctl_a()), 32'(c_freeze));
    step();
    step();
    chk("release_lu_ctl", 32'(ctl_a()), 32'(c_ld_use));
    step();
    clear_a();
    chk("release_lu_load_stat", 32'(bus_a.stat_load_stall), 32'd3);
    chk("release_lu_mem_stat", 32'(bus_a.stat_mem_stall), 32'd9);

    // Reset asserted mid-wait (wait_cnt=1)
    bus_a.mem_ram_req = 1'b1;
    step();
    chk("pre_reset_freeze", 32'(ctl_a()), 32'(c_freeze));
    rst = 1'b0;
    #1;
    chk("async_reset_ctl", 32'(ctl_a()), 32'(c_idle));
    chk("async_reset_stats", 32'({bus_a.stat_load_stall, bus_a.stat_mem_stall,
                                  bus_a.stat_flush}), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("post_reset_freeze0", 32'(ctl_a()), 32'(c_freeze));
    step();
    chk("post_reset_freeze1", 32'(ctl_a()), 32'(c_freeze));
    step();
    chk("post_reset_release", 32'(ctl_a()), 32'(c_rel));
    step();
    clear_a();
    chk("post_reset_mem_stat", 32'(bus_a.stat_mem_stall), 32'd3);

    // Saturation of the 4-bit load-use counter, then clear
    set_load_use_a();
    repeat (20) step();
    chk("sat_load_stat", 32'(bus_a.stat_load_stall), 32'd15);
    bus_a.perf_clr = 1'b1;
    step();
    chk("clr_load_stat", 32'(bus_a.stat_load_stall), 32'd0);
    chk("clr_mem_stat", 32'(bus_a.stat_mem_stall), 32'd0);
    clear_a();

    // RAM_WAIT=1: every request cycle is a release, never a freeze
    bus_b.mem_ram_req = 1'b1;
    #1;
    chk("rw1_release0", 32'(ctl_b()), 32'(c_rel));
    step();
    chk("rw1_release1", 32'(ctl_b()), 32'(c_rel));
    step();
    bus_b.mem_ram_req = 1'b0;
    #1;
    chk("rw1_mem_stat", 32'(bus_b.stat_mem_stall), 32'd2);
    chk("rw1_idle_ctl", 32'(ctl_b()), 32'(c_idle));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
